// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared types, defaults and thermometer helper for popcount blocks
package popcount_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int N_DEF = 7;
  localparam int W_DEF = 3;
  localparam int N_MAX = 15;

  // Bit i is set when i < cnt; callers truncate to their own frame length.
  function automatic logic [N_MAX-1:0] therm(input int cnt);
    logic [N_MAX-1:0] t;
    for (int i = 0; i < N_MAX; i++) begin
      t[i] = (i < cnt);
    end
    return t;
  endfunction

endpackage

// File: rtl/popcount07_unary_gen_if.sv
// rtl/popcount07_unary_gen_if.sv - count input / unary output handshake bundle
interface popcount07_unary_gen_if
  import popcount_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_count;
  logic         out_valid;
  logic         out_ready;
  logic         out_bit;
  logic         out_last;
  logic [N-1:0] out_vec;
  logic         sat_err;

  modport master (
    output in_valid, in_count, out_ready,
    input  in_ready, out_valid, out_bit, out_last, out_vec, sat_err
  );

  modport slave (
    input  in_valid, in_count, out_ready,
    output in_ready, out_valid, out_bit, out_last, out_vec, sat_err
  );

endinterface

// File: rtl/popcount_therm_enc.sv
// rtl/popcount_therm_enc.sv - clamp a count to N and encode it as an N-bit thermometer
module popcount_therm_enc
  import popcount_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic [W-1:0] count,
  output logic [N-1:0] vec,
  output logic         sat
);

  localparam logic [W-1:0] N_W = W'(N);

  logic [W-1:0] clamped;

  always_comb begin
    sat     = (count > N_W);
    clamped = sat ? N_W : count;
    vec     = N'(therm(int'(clamped)));
  end

endmodule

// File: rtl/popcount07_unary_gen.sv
// rtl/popcount07_unary_gen.sv - serialise a count as an LSB-first unary thermometer frame
module popcount07_unary_gen
  import popcount_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  popcount07_unary_gen_if.slave  bus
);

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] sr;
  logic [N-1:0] enc_vec;
  logic [W-1:0] idx;
  logic         enc_sat;
  logic         last;
  logic         accept;
  logic         fire;

  popcount_therm_enc #(.N(N), .W(W)) u_enc (
    .count (bus.in_count),
    .vec   (enc_vec),
    .sat   (enc_sat)
  );

  assign last   = (idx == LAST_IDX);
  assign accept = bus.in_valid && bus.in_ready;
  assign fire   = bus.out_valid && bus.out_ready;

  assign bus.out_bit  = bus.out_valid && sr[0];
  assign bus.out_last = bus.out_valid && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // in_ready follows out_ready combinationally so a new frame can start with no bubble.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready && last;
        if (bus.out_ready && last) begin
          state_nxt = bus.in_valid ? SHIFT : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr          <= '0;
      idx         <= '0;
      bus.out_vec <= '0;
      bus.sat_err <= 1'b0;
    end else begin
      bus.sat_err <= accept && enc_sat;
      if (accept) begin
        sr          <= enc_vec;
        bus.out_vec <= enc_vec;
        idx         <= '0;
      end else if (fire) begin
        sr  <= sr >> 1;
        idx <= last ? '0 : idx + W'(1);
      end
    end
  end

endmodule

// File: tb/tb_popcount07_unary_gen.sv
// tb/tb_popcount07_unary_gen.sv - directed and round-trip checks of the unary frame generator
module tb_popcount07_unary_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  popcount07_unary_gen_if #(.N(7), .W(3)) bus7 ();
  popcount07_unary_gen_if #(.N(5), .W(3)) bus5 ();

  popcount07_unary_gen #(.N(7), .W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus7));
  popcount07_unary_gen #(.N(5), .W(3)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model of the N=7 instance: frame position and requested count.
  bit   busy = 0;
  int   pos = 0, cur_cnt = 0, exp_vec = 0, exp_sat = 0, cur_ones = 0;
  int   cyc = 0, acc_n = 0;
  bit   bitlog[$];
  int   acc_cyc[$], last_cyc[$], frame_pc[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      busy = 0; pos = 0; cur_cnt = 0; exp_vec = 0; exp_sat = 0; cur_ones = 0;
    end
    chk("out_valid", bus7.out_valid, busy);
    chk("in_ready", bus7.in_ready, (!busy || (bus7.out_ready && pos == 6)));
    chk("out_bit", bus7.out_bit, (busy && pos < cur_cnt));
    chk("out_last", bus7.out_last, (busy && pos == 6));
    chk("out_vec", bus7.out_vec, exp_vec);
    chk("sat_err", bus7.sat_err, exp_sat);
    if (rst_n) begin
      exp_sat = 0;
      if (bus7.out_valid && bus7.out_ready) begin
        bitlog.push_back(bus7.out_bit);
        cur_ones += bus7.out_bit;
        pos++;
        if (pos == 7) begin
          busy = 0; pos = 0;
          last_cyc.push_back(cyc);
          frame_pc.push_back(cur_ones);
          cur_ones = 0;
        end
      end
      if (bus7.in_valid && bus7.in_ready) begin
        acc_n++;
        acc_cyc.push_back(cyc);
        cur_cnt = (bus7.in_count > 7) ? 7 : int'(bus7.in_count);
        busy    = 1; pos = 0;
        exp_vec = (1 << cur_cnt) - 1;
        exp_sat = (bus7.in_count > 7);
      end
    end
  end

  bit bitlog5[$];
  int sat5 = 0, last5 = 0;

  always @(negedge clk) begin
    if (rst_n && bus5.out_valid && bus5.out_ready) begin
      bitlog5.push_back(bus5.out_bit);
      if (bus5.out_last) last5++;
    end
    if (bus5.sat_err) sat5++;
  end

  int rdy_mode = 0;
  int pidx = 0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       bus7.out_ready = (pidx % 3 == 0);
      2:       bus7.out_ready = ($urandom_range(0, 3) != 0);
      default: bus7.out_ready = 1'b1;
    endcase
    pidx++;
  end

  function automatic int pack(input bit q[$], input int n);
    int v = 0;
    for (int i = 0; i < n && i < q.size(); i++) v |= int'(q[i]) << i;
    return v;
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear();
    bitlog.delete(); acc_cyc.delete(); last_cyc.delete(); frame_pc.delete();
  endtask

  task automatic send(input logic [2:0] c);
    int n0;
    #1;
    n0 = acc_n;
    bus7.in_valid = 1'b1;
    bus7.in_count = c;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (acc_n != n0) break;
    end
    #1;
    bus7.in_valid = 1'b0;
    chk("send_accepted", acc_n - n0, 1);
  endtask

  task automatic wait_bits(input int n);
    for (int k = 0; k < 300; k++) begin
      if (bitlog.size() >= n) break;
      @(posedge clk);
    end
    chk("wait_bits", int'(bitlog.size() >= n), 1);
  endtask

  int sent[$];

  initial begin
    bus7.in_valid = 1'b0; bus7.in_count = '0; bus7.out_ready = 1'b1;
    bus5.in_valid = 1'b0; bus5.in_count = '0; bus5.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus7.in_ready, 1);
    chk("rst_out_valid", bus7.out_valid, 0);
    chk("rst_out_vec", bus7.out_vec, 0);
    chk("rst_sat_err", bus7.sat_err, 0);
    rst_n = 1'b1;
    @(posedge clk);

    // Count 5 with no backpressure.
    clear();
    send(3'd5);
    wait_bits(7);
    @(posedge clk);
    chk("t1_bits", pack(bitlog, 7), 7'b0011111);
    chk("t1_vec", bus7.out_vec, 7'b0011111);
    chk("t1_last_frames", last_cyc.size(), 1);
    chk("t1_latency", qget(last_cyc, 0) - qget(acc_cyc, 0), 7);

    // Count 0 then 7 back to back.
    clear();
    send(3'd0);
    send(3'd7);
    wait_bits(14);
    @(posedge clk);
    chk("t2_bits", pack(bitlog, 14), 14'h3F80);
    chk("t2_no_bubble", qget(acc_cyc, 1), qget(last_cyc, 0));
    chk("t2_second_last", qget(last_cyc, 1) - qget(last_cyc, 0), 7);

    // Count 3 under a 1,0,0 ready pattern.
    @(posedge clk);
    #2;
    pidx = 0;
    rdy_mode = 1;
    clear();
    send(3'd3);
    wait_bits(7);
    @(posedge clk);
    chk("t3_bits", pack(bitlog, 7), 7'b0000111);
    chk("t3_ones", qget(frame_pc, 0), 3);
    chk("t3_stretched", int'(qget(last_cyc, 0) - qget(acc_cyc, 0) > 7), 1);
    rdy_mode = 0;
    repeat (2) @(posedge clk);

    // N=5 instance with an over-range count.
    #1;
    chk("t4_in_ready", bus5.in_ready, 1);
    bus5.in_valid = 1'b1;
    bus5.in_count = 3'd7;
    @(posedge clk);
    #1;
    bus5.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    chk("t4_bits", pack(bitlog5, 5), 5'b11111);
    chk("t4_nbits", bitlog5.size(), 5);
    chk("t4_vec", bus5.out_vec, 5'b11111);
    chk("t4_sat_pulses", sat5, 1);
    chk("t4_last", last5, 1);

    // Reset in the middle of a count-6 frame.
    clear();
    send(3'd6);
    wait_bits(3);
    #2;
    chk("t5_busy_before", bus7.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", bus7.out_valid, 0);
    chk("t5_out_bit", bus7.out_bit, 0);
    chk("t5_out_last", bus7.out_last, 0);
    chk("t5_out_vec", bus7.out_vec, 0);
    chk("t5_sat_err", bus7.sat_err, 0);
    chk("t5_in_ready", bus7.in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("t5_ready_after", bus7.in_ready, 1);
    clear();
    send(3'd2);
    wait_bits(7);
    @(posedge clk);
    chk("t5_bits", pack(bitlog, 7), 7'b0000011);
    chk("t5_frames", frame_pc.size(), 1);

    // Round trip with random gaps and backpressure.
    rdy_mode = 2;
    clear();
    for (int i = 0; i < 16; i++) begin
      int c;
      c = (i < 8) ? (7 - i) : int'($urandom_range(0, 7));
      sent.push_back(c);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(3'(c));
    end
    for (int k = 0; k < 2000 && frame_pc.size() < 16; k++) @(posedge clk);
    chk("rt_frames", frame_pc.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("rt_popcount", qget(frame_pc, i), (sent[i] > 7) ? 7 : sent[i]);
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
